// File: rtl/memctl_arb.sv
// Round-robin arbiter sharing one 32-bit BRAM port between NPORTS halfword requesters.
// Latency: grant and BRAM strobes are combinational in the accept cycle; read data returns BRAM_LAT+1 cycles later.
// Backpressure: a requester holds req until gnt; one access per cycle, reads fully pipelined with no stalls.
module memctl_arb #(
    parameter int NPORTS   = 2,
    parameter int ADDR_W   = 16,
    parameter int BRAM_LAT = 1,
    parameter int SWAP     = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*16-1:0]     wdata,
    input  logic [NPORTS*2-1:0]      be,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        rvalid,
    output logic [15:0]              rdata,
    output logic [31:0]              bram_addr,
    output logic [31:0]              bram_data_out,
    input  logic [31:0]              bram_data_in,
    output logic                     bram_en,
    output logic [3:0]               bram_we
);

    localparam int PW   = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int LAST = BRAM_LAT - 1;

    // Byte swap within a halfword; the same swap is applied on write and read so it cancels end to end.
    function automatic logic [15:0] swap16(input logic [15:0] x);
        return (SWAP != 0) ? {x[7:0], x[15:8]} : x;
    endfunction

    logic [PW-1:0]       last_q;
    logic [PW-1:0]       sel;
    logic                acc;
    logic [ADDR_W-1:0]   sel_addr;
    logic [15:0]         sel_wdata;
    logic [1:0]          sel_be;
    logic                sel_we;
    logic [1:0]          lane_be;
    logic [15:0]         lane_data;

    logic [BRAM_LAT-1:0] tag_vld;
    logic [PW-1:0]       tag_port [BRAM_LAT];
    logic                tag_lane [BRAM_LAT];
    logic [NPORTS-1:0]   rvalid_q;
    logic [15:0]         rdata_q;

    // Round-robin search starting one past the last granted port; nothing is granted during reset.
    always_comb begin
        gnt = '0;
        sel = '0;
        acc = 1'b0;
        for (int i = 1; i <= NPORTS; i++) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (!acc && !rst && req[j] && (j == (int'(last_q) + i) % NPORTS)) begin
                    acc    = 1'b1;
                    sel    = PW'(j);
                    gnt[j] = 1'b1;
                end
            end
        end
    end

    // Route the granted port's request fields onto the BRAM side.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_we    = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            if (gnt[j]) begin
                sel_addr  = addr[j*ADDR_W +: ADDR_W];
                sel_wdata = wdata[j*16 +: 16];
                sel_be    = be[j*2 +: 2];
                sel_we    = we[j];
            end
        end
    end

    // addr[0]=0 targets the upper lane (bytes 3:2), addr[0]=1 the lower lane (bytes 1:0).
    assign lane_data     = swap16(sel_wdata);
    assign lane_be       = (SWAP != 0) ? {sel_be[0], sel_be[1]} : sel_be;
    assign bram_en       = acc;
    assign bram_addr     = 32'({sel_addr[ADDR_W-1:1], 2'b00});
    assign bram_data_out = sel_addr[0] ? {16'h0000, lane_data} : {lane_data, 16'h0000};
    assign bram_we       = (acc && sel_we) ? (sel_addr[0] ? {2'b00, lane_be} : {lane_be, 2'b00}) : 4'b0000;

    // Remember the last winner so the next search starts after it.
    always_ff @(posedge clk) begin
        if (rst)
            last_q <= PW'(NPORTS - 1);
        else if (acc)
            last_q <= sel;
    end

    // Tag pipeline tracks each read until its BRAM data arrives; reset discards reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else begin
            tag_vld[0] <= acc && !sel_we;
            for (int s = 1; s < BRAM_LAT; s++)
                tag_vld[s] <= tag_vld[s-1];
        end
        tag_port[0] <= sel;
        tag_lane[0] <= sel_addr[0];
        for (int s = 1; s < BRAM_LAT; s++) begin
            tag_port[s] <= tag_port[s-1];
            tag_lane[s] <= tag_lane[s-1];
        end
    end

    // Capture the tagged lane into rdata and pulse rvalid for its port; rdata holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= 16'h0000;
        end else begin
            rvalid_q <= '0;
            if (tag_vld[LAST]) begin
                for (int j = 0; j < NPORTS; j++)
                    if (tag_port[LAST] == PW'(j))
                        rvalid_q[j] <= 1'b1;
                rdata_q <= tag_lane[LAST] ? swap16(bram_data_in[15:0]) : swap16(bram_data_in[31:16]);
            end
        end
    end

    // Outputs read as idle for the whole time reset is held, including its first cycle.
    assign rvalid = rst ? '0 : rvalid_q;
    assign rdata  = rst ? 16'h0000 : rdata_q;

endmodule

// File: tb/tb_memctl_arb.sv
// Bench for memctl_arb: two instances (BRAM_LAT=1/SWAP=1 and BRAM_LAT=2/SWAP=0) share one stimulus stream.
// A halfword-level memory model predicts read data; a byte-placement model predicts BRAM strobes.
// Directed opening sequence, then randomized requests with occasional resets.
module tb_memctl_arb;

    localparam int NCYC = 1500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic [1:0]  gnt    [2];
    logic [1:0]  rvalid [2];
    logic [15:0] rdata  [2];
    logic [31:0] baddr  [2];
    logic [31:0] bdo    [2];
    logic [31:0] bdi    [2];
    logic        ben    [2];
    logic [3:0]  bwe    [2];

    memctl_arb #(.NPORTS(2), .ADDR_W(16), .BRAM_LAT(1), .SWAP(1)) u_lat1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .bram_addr(baddr[0]),
        .bram_data_out(bdo[0]), .bram_data_in(bdi[0]), .bram_en(ben[0]), .bram_we(bwe[0])
    );

    memctl_arb #(.NPORTS(2), .ADDR_W(16), .BRAM_LAT(2), .SWAP(0)) u_lat2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .bram_addr(baddr[1]),
        .bram_data_out(bdo[1]), .bram_data_in(bdi[1]), .bram_en(ben[1]), .bram_we(bwe[1])
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    // Environment and reference state
    int          lat [2];
    int          sw  [2];
    logic [15:0] lmem [65536];
    logic [31:0] bmem [2][16384];
    logic [31:0] brd  [2][NCYC];
    logic        acc_vld  [NCYC];
    int          acc_port [NCYC];
    logic [15:0] acc_data [NCYC];
    logic [15:0] exp_rd [2];
    int          last_g, ep, hi_pos, lo_pos, d, word;
    logic [1:0]  eg, erv, b;
    logic [15:0] a, w;
    logic        iswr;
    logic [31:0] edo;
    logic [3:0]  ewe;

    function automatic logic [15:0] rand_addr();
        logic [15:0] x;
        x = 16'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0)
            x = x | 16'hFFF0;
        return x;
    endfunction

    task automatic set_inputs(input int c);
        rst = 1'b0; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; be = '0;
        case (c)
            0, 1, 10, 18: rst = 1'b1;
            2:  begin req = 2'b01; we = 2'b01; addr[15:0] = 16'h0002; wdata[15:0] = 16'h1234; be[1:0] = 2'b11; end
            3:  begin req = 2'b01; addr[15:0] = 16'h0002; end
            4:  begin req = 2'b01; we = 2'b01; addr[15:0] = 16'h0002; wdata[15:0] = 16'hFFFF; be[1:0] = 2'b11; end
            5:  begin req = 2'b01; we = 2'b01; addr[15:0] = 16'h0003; wdata[15:0] = 16'hAB00; be[1:0] = 2'b10; end
            6:  begin req = 2'b01; addr[15:0] = 16'h0003; end
            7, 8, 9: ;
            11, 12, 13, 14: begin req = 2'b11; addr = {16'h0003, 16'h0002}; end
            15, 16: begin req = 2'b10; addr = {16'h0003, 16'h0000}; end
            17: begin req = 2'b01; addr[15:0] = 16'h0002; end
            19: begin req = 2'b11; addr = {16'h0003, 16'h0002}; end
            default: begin
                rst   = ($urandom_range(0, 59) == 0);
                req   = 2'($urandom);
                we    = 2'($urandom);
                addr  = {rand_addr(), rand_addr()};
                wdata = $urandom;
                be    = 4'($urandom);
            end
        endcase
    endtask

    initial begin
        lat[0] = 1; sw[0] = 1;
        lat[1] = 2; sw[1] = 0;
        for (int i = 0; i < 65536; i++) lmem[i] = 16'h0000;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16384; i++) bmem[k][i] = 32'h0;
        for (int i = 0; i < NCYC; i++) acc_vld[i] = 1'b0;
        exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
        last_g = 1;
        bdi[0] = '0; bdi[1] = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            set_inputs(c);
            // BRAM output for this cycle: the word read BRAM_LAT cycles ago
            for (int k = 0; k < 2; k++)
                bdi[k] = (c - lat[k] >= 0) ? brd[k][c - lat[k]] : 32'h0;
            #1;

            // Round-robin expectation
            ep = -1;
            if (!rst)
                for (int i = 1; i <= 2; i++)
                    if (ep < 0 && req[(last_g + i) % 2]) ep = (last_g + i) % 2;
            eg   = (ep >= 0) ? 2'(1 << ep) : 2'b00;
            a    = (ep >= 0) ? addr[ep*16 +: 16] : 16'h0;
            w    = (ep >= 0) ? wdata[ep*16 +: 16] : 16'h0;
            b    = (ep >= 0) ? be[ep*2 +: 2] : 2'b00;
            iswr = (ep >= 0) ? we[ep] : 1'b0;

            for (int k = 0; k < 2; k++) begin
                chk("gnt", 32'(gnt[k]), 32'(eg));
                chk("bram_en", 32'(ben[k]), 32'(ep >= 0));
                // Byte positions of the halfword's high and low byte inside the BRAM word
                if (a[0] == 1'b0) begin hi_pos = sw[k] ? 2 : 3; lo_pos = sw[k] ? 3 : 2; end
                else              begin hi_pos = sw[k] ? 0 : 1; lo_pos = sw[k] ? 1 : 0; end
                edo = (32'(w[15:8]) << (8*hi_pos)) | (32'(w[7:0]) << (8*lo_pos));
                ewe = iswr ? 4'((32'(b[1]) << hi_pos) | (32'(b[0]) << lo_pos)) : 4'b0000;
                chk("bram_we", 32'(bwe[k]), 32'(ewe));
                if (ep >= 0) chk("bram_addr", baddr[k], 32'(a[15:1]) << 2);
                if (iswr)    chk("bram_data_out", bdo[k], edo);

                // Read return expectation
                d   = c - lat[k] - 1;
                erv = 2'b00;
                if (rst)
                    exp_rd[k] = 16'h0;
                else if (d >= 0 && acc_vld[d]) begin
                    erv       = 2'(1 << acc_port[d]);
                    exp_rd[k] = acc_data[d];
                end
                chk("rvalid", 32'(rvalid[k]), 32'(erv));
                chk("rdata", 32'(rdata[k]), 32'(exp_rd[k]));

                // Read-first BRAM behaviour driven by the DUT's own strobes
                brd[k][c] = (c > 0) ? brd[k][c-1] : 32'h0;
                if (ben[k]) begin
                    word = int'(baddr[k][15:2]);
                    brd[k][c] = bmem[k][word];
                    for (int i = 0; i < 4; i++)
                        if (bwe[k][i]) bmem[k][word][8*i +: 8] = bdo[k][8*i +: 8];
                end
            end

            // Directed spot checks with hand-computed constants
            if (c == 2) begin
                chk("wr_addr", baddr[0], 32'h0000_0004);
                chk("wr_we_swap", 32'(bwe[0]), 32'h0000_000C);
                chk("wr_dout_swap", bdo[0], 32'h3412_0000);
                chk("wr_dout_noswap", bdo[1], 32'h1234_0000);
            end
            if (c == 5) begin
                chk("rd_rvalid_lat1", 32'(rvalid[0]), 32'h1);
                chk("rd_data_lat1", 32'(rdata[0]), 32'h1234);
                chk("byte_we_swap", 32'(bwe[0]), 32'h1);
                chk("byte_we_noswap", 32'(bwe[1]), 32'h2);
            end
            if (c == 6) chk("rd_data_noswap", 32'(rdata[1]), 32'h1234);
            if (c == 8) chk("byte_rd_hi", 32'(rdata[0][15:8]), 32'hAB);
            if (c == 11) chk("rr_first", 32'(gnt[0]), 32'h1);
            if (c == 12) chk("rr_second", 32'(gnt[0]), 32'h2);
            if (c == 16) chk("rr_port1_only", 32'(gnt[0]), 32'h2);
            if (c == 14) chk("pipe_rv0", 32'(rvalid[1]), 32'h1);
            if (c == 15) chk("pipe_rv1", 32'(rvalid[1]), 32'h2);
            if (c == 16) chk("pipe_rd2", 32'(rdata[1]), 32'hFFFF);
            if (c == 19) chk("post_rst_prio", 32'(gnt[1]), 32'h1);
            if (c == 20) chk("rst_drop_rd", 32'(rvalid[0]), 32'h0);

            // Reference state update at the clock edge
            if (rst) begin
                last_g = 1;
                for (int j = c - 3; j < c; j++)
                    if (j >= 0) acc_vld[j] = 1'b0;
            end
            acc_vld[c] = 1'b0;
            if (ep >= 0) begin
                last_g = ep;
                if (!iswr) begin
                    acc_vld[c]  = 1'b1;
                    acc_port[c] = ep;
                    acc_data[c] = lmem[a];
                end else begin
                    if (b[1]) lmem[a][15:8] = w[15:8];
                    if (b[0]) lmem[a][7:0]  = w[7:0];
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
